// File: rtl/key_sched_ctrl.sv
// Key-schedule controller: clears and loads key_reg from a byte stream, then
// XORs run data with the stored keys round-robin. Optional LOAD idle timeout: KSC_TIMEOUT_EN.
module key_sched_ctrl #(
  parameter int KEY_W    = 8,
  parameter int MAX_KEYS = 4
`ifdef KSC_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic                      dclk,
  input  logic                      reset,
  input  logic                      cmd_load,
  input  logic                      cmd_run,
  input  logic                      in_valid,
  input  logic [KEY_W-1:0]          in_data,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      kclr,
  output logic                      kset,
  output logic [KEY_W-1:0]          kdin,
  input  logic [3:0]                num_keys,
  input  logic [MAX_KEYS*KEY_W-1:0] keys,
  output logic                      out_valid,
  output logic [KEY_W-1:0]          out_data,
  input  logic                      out_ready,
  output logic [1:0]                key_idx,
  output logic                      busy,
  output logic                      err
);

  localparam int CNT_W = $clog2(MAX_KEYS + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_DRAIN} state_t;

  state_t             state_reg, state_next;
  logic               out_valid_reg, out_valid_next;
  logic [KEY_W-1:0]   out_data_reg, out_data_next;
  logic [1:0]         key_idx_reg, key_idx_next;
  logic [CNT_W-1:0]   load_cnt_reg, load_cnt_next;
  logic               err_reg, err_next;
  logic [3:0]         eff_keys;
  logic [3:0]         last_idx;
  logic [KEY_W-1:0]   key_slot [MAX_KEYS];
  logic               accept;

`ifdef KSC_TIMEOUT_EN
  logic [7:0]         idle_cnt_reg, idle_cnt_next;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < MAX_KEYS; gi++) begin : g_slot
      assign key_slot[gi] = keys[gi*KEY_W +: KEY_W];
    end
  endgenerate

  // key_reg may report more keys than it has slots; never index past them.
  assign eff_keys = (num_keys > 4'(MAX_KEYS)) ? 4'(MAX_KEYS) : num_keys;
  assign last_idx = eff_keys - 4'd1;
  assign accept   = in_valid && in_ready;

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign key_idx   = key_idx_reg;
  assign err       = err_reg;
  assign busy      = (state_reg != S_IDLE);

  always_comb begin
    state_next     = state_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    key_idx_next   = key_idx_reg;
    load_cnt_next  = load_cnt_reg;
    err_next       = 1'b0;
    in_ready       = 1'b0;
    kclr           = 1'b0;
    kset           = 1'b0;
    kdin           = in_data;
`ifdef KSC_TIMEOUT_EN
    idle_cnt_next  = idle_cnt_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (cmd_load) begin
          state_next = S_CLEAR;
        end else if (cmd_run) begin
          if (eff_keys != 4'd0) begin
            state_next   = S_RUN;
            key_idx_next = 2'd0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        kclr          = 1'b1;
        load_cnt_next = '0;
`ifdef KSC_TIMEOUT_EN
        idle_cnt_next = 8'd0;
`endif
        state_next    = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        kset     = in_valid;
        if (in_valid) begin
          load_cnt_next = load_cnt_reg + 1'b1;
`ifdef KSC_TIMEOUT_EN
          idle_cnt_next = 8'd0;
`endif
          // Leaving at the last slot means key_reg never sees an extra kset.
          if (in_last || (load_cnt_reg == CNT_W'(MAX_KEYS - 1))) begin
            state_next = S_IDLE;
          end
        end
`ifdef KSC_TIMEOUT_EN
        else if (idle_cnt_reg == 8'(TIMEOUT - 1)) begin
          state_next = S_IDLE;
          err_next   = 1'b1;
        end else begin
          idle_cnt_next = idle_cnt_reg + 8'd1;
        end
`endif
      end
      S_RUN: begin
        in_ready = !out_valid_reg || out_ready;
        if (accept) begin
          out_data_next  = in_data ^ key_slot[key_idx_reg];
          out_valid_next = 1'b1;
          key_idx_next   = ({2'b00, key_idx_reg} == last_idx) ? 2'd0 : key_idx_reg + 2'd1;
          if (in_last) begin
            state_next = S_DRAIN;
          end
        end else if (out_valid_reg && out_ready) begin
          out_valid_next = 1'b0;
        end
      end
      S_DRAIN: begin
        if (!out_valid_reg || out_ready) begin
          out_valid_next = 1'b0;
          key_idx_next   = 2'd0;
          state_next     = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge dclk) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      key_idx_reg   <= 2'd0;
      load_cnt_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      key_idx_reg   <= key_idx_next;
      load_cnt_reg  <= load_cnt_next;
      err_reg       <= err_next;
    end
  end

`ifdef KSC_TIMEOUT_EN
  always_ff @(posedge dclk) begin
    if (!reset) begin
      idle_cnt_reg <= 8'd0;
    end else begin
      idle_cnt_reg <= idle_cnt_next;
    end
  end
`endif

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: key_reg model, XOR scoreboard and literal pins.
// Built with KSC_TIMEOUT_EN it exercises the LOAD timeout with TIMEOUT=10.
module tb_key_sched_ctrl;

  logic       dclk = 0, reset = 0, cmd_load = 0, cmd_run = 0;
  logic       in_valid = 0, in_last = 0, out_ready = 1;
  logic [7:0] in_data = 0;
  logic       in_ready, kclr, kset, out_valid, busy, err;
  logic [7:0] kdin, out_data;
  logic [1:0] key_idx;
  logic [3:0] nk = 4'd0;
  logic [7:0] kmem [4] = '{default: 8'h00};
  logic [31:0] keys;

  int checks = 0, failures = 0;
  int kclr_cnt = 0, kset_cnt = 0;
  int ridx = 0;
  logic [7:0] exp_q [$];
  logic [7:0] out_log [$];

  assign keys = {kmem[3], kmem[2], kmem[1], kmem[0]};

  always #5 dclk = ~dclk;

`ifdef KSC_TIMEOUT_EN
  key_sched_ctrl #(.TIMEOUT(10)) dut (
`else
  key_sched_ctrl dut (
`endif
    .dclk(dclk), .reset(reset), .cmd_load(cmd_load), .cmd_run(cmd_run),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .kclr(kclr), .kset(kset), .kdin(kdin), .num_keys(nk), .keys(keys),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .key_idx(key_idx), .busy(busy), .err(err)
  );

  // key_reg: clear on kclr, otherwise append kdin into the next free slot.
  always @(posedge dclk) begin
    if (kclr) begin
      nk <= 4'd0;
      for (int i = 0; i < 4; i++) kmem[i] <= 8'h00;
    end else if (kset && nk < 4'd4) begin
      kmem[nk[1:0]] <= kdin;
      nk <= nk + 4'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Sampling one time unit before each rising edge.
  initial begin : mon
    logic       hold;
    logic [7:0] held, e;
    hold = 0;
    held = 0;
    forever begin
      @(negedge dclk);
      #4;
      if (!reset) begin
        hold = 0;
      end else begin
        if (kclr) kclr_cnt++;
        if (kset) kset_cnt++;
        if (hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, held);
        end
        hold = 0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got %h expected no output", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e);
            out_log.push_back(out_data);
          end
        end else if (out_valid) begin
          chk("stall_in_ready", in_ready, 0);
          hold = 1;
          held = out_data;
        end
      end
    end
  end

  // Offer one byte from a negedge; returns at the negedge after the transfer.
  task automatic send(input logic [7:0] d, input logic l, input bit is_run);
    int w = 0;
    in_valid = 1; in_data = d; in_last = l;
    #4;
    while (!in_ready && w < 40) begin
      @(negedge dclk);
      #4;
      w++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for byte %h", d);
    end else if (is_run) begin
      chk("key_idx", key_idx, ridx);
      exp_q.push_back(d ^ kmem[ridx]);
      ridx = (ridx + 1) % int'(nk);
    end else begin
      chk("kset", kset, 1);
      chk("kdin", kdin, d);
    end
    @(negedge dclk);
    in_valid = 0; in_last = 0;
  endtask

  task automatic pulse_load();
    cmd_load = 1;
    @(negedge dclk);
    cmd_load = 0;
  endtask

  task automatic pulse_run();
    cmd_run = 1;
    ridx = 0;
    @(negedge dclk);
    cmd_run = 0;
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    #4;
    while (busy && w < 40) begin
      @(negedge dclk);
      #4;
      w++;
    end
    chk(name, busy, 0);
    @(negedge dclk);
  endtask

  initial begin
    logic [7:0] e6 [6];
    logic [7:0] e3 [3];
    logic [7:0] e1 [3];
    int         pat [8];
    int         k0, s0;
    e6  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
    e3  = '{8'h5A, 8'hA5, 8'h5A};
    e1  = '{8'h33, 8'hCC, 8'h3C};
    pat = '{1, 1, 0, 1, 0, 1, 1, 1};

    // Reset
    repeat (2) @(negedge dclk);
    #4;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_key_idx", key_idx, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge dclk);
    reset = 1;
    @(negedge dclk);

    // cmd_run with no keys
    pulse_run();
    #4;
    chk("nokey_err", err, 1);
    chk("nokey_busy", busy, 0);
    @(negedge dclk);
    #4;
    chk("nokey_err_drop", err, 0);
    @(negedge dclk);

    // Load four keys back-to-back
    k0 = kclr_cnt; s0 = kset_cnt;
    pulse_load();
    #4;
    chk("load4_kclr", kclr, 1);
    @(negedge dclk);
    send(8'h11, 0, 0);
    send(8'h22, 0, 0);
    send(8'h33, 0, 0);
    send(8'h44, 0, 0);
    in_valid = 1; in_data = 8'h55;
    #4;
    chk("load4_idle", busy, 0);
    chk("load4_5th_ready", in_ready, 0);
    chk("load4_5th_kset", kset, 0);
    @(negedge dclk);
    in_valid = 0;
    chk("load4_kclr_cycles", kclr_cnt - k0, 1);
    chk("load4_kset_cycles", kset_cnt - s0, 4);
    chk("load4_num_keys", nk, 4);
    chk("load4_keys", keys, 32'h44332211);

    // Run six zero bytes
    out_log.delete();
    pulse_run();
    for (int i = 0; i < 6; i++) send(8'h00, i == 5, 1);
    wait_idle("run6_idle");
    chk("run6_key_idx", key_idx, 0);
    chk("run6_pending", exp_q.size(), 0);
    chk("run6_count", out_log.size(), 6);
    for (int i = 0; i < out_log.size() && i < 6; i++) chk("run6_lit", out_log[i], e6[i]);

    // Two keys, in_last on the second byte
    pulse_load();
    send(8'hA5, 0, 0);
    send(8'h5A, 1, 0);
    #4;
    chk("load2_idle", busy, 0);
    @(negedge dclk);
    chk("load2_num_keys", nk, 2);
    chk("load2_keys", keys[15:0], 16'h5AA5);

    // Run three bytes with backpressure
    out_log.delete();
    pulse_run();
    fork
      begin
        for (int i = 0; i < 3; i++) send(8'hFF, i == 2, 1);
      end
      begin
        for (int i = 0; i < 8; i++) begin
          out_ready = pat[i][0];
          @(negedge dclk);
        end
      end
    join
    out_ready = 1;
    wait_idle("run3_idle");
    chk("run3_count", out_log.size(), 3);
    for (int i = 0; i < out_log.size() && i < 3; i++) chk("run3_lit", out_log[i], e3[i]);

    // Single key: in_last on the first byte, key_idx pinned at 0
    pulse_load();
    send(8'h3C, 1, 0);
    chk("load1_num_keys", nk, 1);
    out_log.delete();
    pulse_run();
    send(8'h0F, 0, 1);
    send(8'hF0, 0, 1);
    send(8'h00, 1, 1);
    wait_idle("run1_idle");
    chk("run1_count", out_log.size(), 3);
    for (int i = 0; i < out_log.size() && i < 3; i++) chk("run1_lit", out_log[i], e1[i]);

    // Reset while a RUN output is pending
    out_ready = 0;
    pulse_run();
    send(8'h01, 0, 1);
    reset = 0;
    @(negedge dclk);
    reset = 1;
    #4;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_key_idx", key_idx, 0);
    chk("midrst_num_keys", nk, 1);
    exp_q.delete();
    @(negedge dclk);
    out_ready = 1;

`ifdef KSC_TIMEOUT_EN
    // LOAD idle timeout
    pulse_load();
    send(8'h77, 0, 0);
    for (int i = 0; i < 10; i++) begin
      #4;
      chk("to_waiting", busy, 1);
      @(negedge dclk);
    end
    #4;
    chk("to_err", err, 1);
    chk("to_idle", busy, 0);
    @(negedge dclk);
    chk("to_num_keys", nk, 1);
`else
    // LOAD waits indefinitely
    pulse_load();
    send(8'h77, 0, 0);
    repeat (300) @(negedge dclk);
    #4;
    chk("wait_busy", busy, 1);
    chk("wait_in_ready", in_ready, 1);
    chk("wait_err", err, 0);
    @(negedge dclk);
    send(8'h88, 1, 0);
    #4;
    chk("wait_idle", busy, 0);
    @(negedge dclk);
    chk("wait_num_keys", nk, 2);
    chk("wait_keys", keys[15:0], 16'h8877);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
